// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: widens a raw decode immediate into an ALU
// operand (sign, zero, shifted branch offset or upper form) and buffers the
// result, its overflow flag and a sideband tag in a small FIFO.
module imm_extend_pipe #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32,
    parameter int SHAMT = 2,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_imm,
    input  logic [1:0]                   in_mode,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_result,
    output logic                         out_ovf,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WIDE_W = OUT_W + SHAMT;
    localparam int UP_SH  = OUT_W - IN_W;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // Extension datapath
    logic [WIDE_W-1:0] w_wide;
    logic [WIDE_W-1:0] w_shl;
    logic [SHAMT:0]    w_top;
    logic [OUT_W-1:0]  w_res;
    logic              w_ovf;

    // FIFO state
    logic [OUT_W-1:0]  r_res [DEPTH];
    logic              r_ovf [DEPTH];
    logic [TAG_W-1:0]  r_tag [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // The immediate is sign-extended once to OUT_W+SHAMT bits; the branch
    // shift then keeps the bits that fall off the top so significance loss
    // can be detected.
    assign w_wide = WIDE_W'($signed(in_imm));
    assign w_shl  = w_wide << SHAMT;
    // Discarded bits plus the new result sign bit must all agree.
    assign w_top  = w_shl[WIDE_W-1:OUT_W-1];

    // Select the extended operand and its overflow flag by mode.
    always_comb begin
        w_res = {OUT_W{1'b0}};
        w_ovf = 1'b0;
        case (in_mode)
            2'b00: begin
                w_res = w_wide[OUT_W-1:0];
                w_ovf = 1'b0;
            end
            2'b01: begin
                w_res = OUT_W'(in_imm);
                w_ovf = 1'b0;
            end
            2'b10: begin
                w_res = w_shl[OUT_W-1:0];
                w_ovf = ~((&w_top) | ~(|w_top));
            end
            2'b11: begin
                w_res = OUT_W'(in_imm) << UP_SH;
                w_ovf = 1'b0;
            end
            default: begin
                w_res = {OUT_W{1'b0}};
                w_ovf = 1'b0;
            end
        endcase
    end

    // Handshake decode depends only on the registered occupancy, so in_ready
    // never sees out_ready combinationally.
    assign w_in_ready  = (r_count < DEPTH_C);
    assign w_out_valid = (r_count != {CNT_W{1'b0}});
    assign w_push      = in_valid & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end else begin
                r_rptr <= r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while unoccupied because the
    // head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset_n && !flush && w_push) begin
            r_res[r_wptr] <= w_res;
            r_ovf[r_wptr] <= w_ovf;
            r_tag[r_wptr] <= in_tag;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign count      = r_count;
    assign out_result = w_out_valid ? r_res[r_rptr] : {OUT_W{1'b0}};
    assign out_ovf    = w_out_valid ? r_ovf[r_rptr] : 1'b0;
    assign out_tag    = w_out_valid ? r_tag[r_rptr] : {TAG_W{1'b0}};

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: expected entries are queued when a
// push is accepted by the reference model and checked at the FIFO head.
module tb_imm_extend_pipe;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic [4:0]  out_tag;
    logic [1:0]  count;

    // Narrow-output instance used for branch overflow
    logic        in_valid2;
    logic        in_ready2;
    logic [16:0] in_imm2;
    logic [1:0]  in_mode2;
    logic [4:0]  in_tag2;
    logic        out_valid2;
    logic        out_ready2;
    logic [17:0] out_result2;
    logic        out_ovf2;
    logic [4:0]  out_tag2;
    logic [1:0]  count2;
    logic        flush2;

    int n_cmp;
    int n_err;
    int cyc;
    logic [37:0] sb_q [$];
    logic [37:0] exp_head;

    imm_extend_pipe #(.IN_W(17), .OUT_W(32), .SHAMT(2), .DEPTH(2), .TAG_W(5)) u_dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ovf(out_ovf), .out_tag(out_tag), .count(count)
    );

    imm_extend_pipe #(.IN_W(17), .OUT_W(18), .SHAMT(2), .DEPTH(2), .TAG_W(5)) u_dut18 (
        .clock(clock), .reset_n(reset_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2),
        .in_mode(in_mode2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_result(out_result2),
        .out_ovf(out_ovf2), .out_tag(out_tag2), .count(count2)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference extension for the default configuration: {ovf, tag, result}
    function automatic logic [37:0] model(input logic [16:0] imm, input logic [1:0] mode,
                                          input logic [4:0] tag);
        logic [31:0] res;
        case (mode)
            2'b00:   res = {{15{imm[16]}}, imm};
            2'b01:   res = {15'd0, imm};
            2'b10:   res = {{13{imm[16]}}, imm, 2'b00};
            default: res = {imm, 15'd0};
        endcase
        return {1'b0, tag, res};
    endfunction

    // Update the model from the inputs driven this cycle, then cross one edge.
    task automatic advance();
        logic acc;
        logic pop;
        acc = reset_n && !flush && in_valid && (sb_q.size() < 2);
        pop = reset_n && !flush && out_ready && (sb_q.size() != 0);
        if (pop) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(model(in_imm, in_mode, in_tag));
        if (!reset_n || flush) sb_q.delete();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [16:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic rdy, input logic fl);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
    endtask

    task automatic test_reset();
        drive(1'b1, 17'h1FFFF, 2'b00, 5'd3, 1'b1, 1'b0);
        reset_n = 1'b0;
        advance();
        n_cmp++;
        if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_status count=%0d valid=%b ready=%b want 0/0/1", count, out_valid, in_ready);
        end
        n_cmp++;
        if ({out_ovf, out_tag, out_result} !== 38'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", {out_ovf, out_tag, out_result});
        end
        drive(1'b0, 17'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        advance();
    endtask

    task automatic test_sign_zero();
        logic        v   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  md  [5] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic [4:0]  tg  [5] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0};
        for (int i = 0; i < 5; i++) begin
            drive(v[i], 17'h1FFFF, md[i], tg[i], 1'b1, 1'b0);
            exp_head = (sb_q.size() != 0) ? sb_q[0] : 38'd0;
            n_cmp++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2)) begin
                n_err++;
                $display("FAIL sz_status cyc=%0d count=%0d want %0d valid=%b", cyc, count, sb_q.size(), out_valid);
            end
            n_cmp++;
            if ({out_ovf, out_tag, out_result} !== exp_head) begin
                n_err++;
                $display("FAIL sz_head cyc=%0d got %h want %h", cyc, {out_ovf, out_tag, out_result}, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_branch_upper();
        logic        v   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [16:0] im  [6] = '{17'h10000, 17'h00001, 17'h0FFFF, 17'h1ABCD, 17'h0, 17'h0};
        logic [1:0]  md  [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
        logic [4:0]  tg  [6] = '{5'd3, 5'd7, 5'd9, 5'd31, 5'd0, 5'd0};
        for (int i = 0; i < 6; i++) begin
            drive(v[i], im[i], md[i], tg[i], 1'b1, 1'b0);
            exp_head = (sb_q.size() != 0) ? sb_q[0] : 38'd0;
            n_cmp++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0)) begin
                n_err++;
                $display("FAIL bu_status cyc=%0d count=%0d want %0d", cyc, count, sb_q.size());
            end
            n_cmp++;
            if ({out_ovf, out_tag, out_result} !== exp_head) begin
                n_err++;
                $display("FAIL bu_head cyc=%0d got %h want %h", cyc, {out_ovf, out_tag, out_result}, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic        v   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [16:0] im  [6] = '{17'h00AAA, 17'h15555, 17'h0C0DE, 17'h0C0DE, 17'h0C0DE, 17'h0C0DE};
        logic [1:0]  md  [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [4:0]  tg  [6] = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd12, 5'd12};
        logic        rd  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 20; i++) begin
            if (i < 6) begin
                drive(v[i], im[i], md[i], tg[i], rd[i], 1'b0);
            end else if (i < 16) begin
                drive(1'($urandom_range(0, 1)), 17'($urandom), 2'($urandom), 5'($urandom),
                      1'($urandom_range(0, 1)), 1'b0);
            end else begin
                drive(1'b0, 17'd0, 2'b00, 5'd0, 1'b1, 1'b0);
            end
            exp_head = (sb_q.size() != 0) ? sb_q[0] : 38'd0;
            n_cmp++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2)) begin
                n_err++;
                $display("FAIL bp_status cyc=%0d count=%0d want %0d ready=%b", cyc, count, sb_q.size(), in_ready);
            end
            n_cmp++;
            if ({out_ovf, out_tag, out_result} !== exp_head) begin
                n_err++;
                $display("FAIL bp_head cyc=%0d got %h want %h", cyc, {out_ovf, out_tag, out_result}, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        logic        v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [16:0] im  [8] = '{17'h00011, 17'h00022, 17'h00033, 17'h00044, 17'h00055, 17'h0, 17'h0, 17'h0};
        logic        fl  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        rd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(v[i], im[i], 2'b01, 5'(i + 1), rd[i], fl[i]);
            exp_head = (sb_q.size() != 0) ? sb_q[0] : 38'd0;
            n_cmp++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2)) begin
                n_err++;
                $display("FAIL fl_status cyc=%0d count=%0d want %0d valid=%b", cyc, count, sb_q.size(), out_valid);
            end
            n_cmp++;
            if ({out_ovf, out_tag, out_result} !== exp_head) begin
                n_err++;
                $display("FAIL fl_head cyc=%0d got %h want %h", cyc, {out_ovf, out_tag, out_result}, exp_head);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        logic v  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic fl [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic rn [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(v[i], 17'h1F0F0, 2'b00, 5'd21, 1'b0, fl[i]);
            reset_n = rn[i];
            exp_head = (sb_q.size() != 0) ? sb_q[0] : 38'd0;
            n_cmp++;
            if (count !== 2'(sb_q.size()) || out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2)) begin
                n_err++;
                $display("FAIL rm_status cyc=%0d count=%0d want %0d ready=%b", cyc, count, sb_q.size(), in_ready);
            end
            n_cmp++;
            if ({out_ovf, out_tag, out_result} !== exp_head) begin
                n_err++;
                $display("FAIL rm_head cyc=%0d got %h want %h", cyc, {out_ovf, out_tag, out_result}, exp_head);
            end
            advance();
        end
        reset_n = 1'b1;
    endtask

    task automatic test_ovf18();
        in_valid2 = 1'b1; in_imm2 = 17'h0C000; in_mode2 = 2'b10; in_tag2 = 5'd4;
        @(posedge clock); #1;
        in_imm2 = 17'h1C000; in_tag2 = 5'd5;
        n_cmp++;
        if ({out_valid2, out_ovf2, out_tag2, out_result2} !== {1'b1, 1'b1, 5'd4, 18'h30000}) begin
            n_err++;
            $display("FAIL ovf18_set got v=%b ovf=%b tag=%0d res=%h want 1/1/4/30000",
                     out_valid2, out_ovf2, out_tag2, out_result2);
        end
        @(posedge clock); #1;
        in_valid2 = 1'b0;
        n_cmp++;
        if ({out_valid2, out_ovf2, out_tag2, out_result2} !== {1'b1, 1'b0, 5'd5, 18'h30000}) begin
            n_err++;
            $display("FAIL ovf18_clear got v=%b ovf=%b tag=%0d res=%h want 1/0/5/30000",
                     out_valid2, out_ovf2, out_tag2, out_result2);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (out_valid2 !== 1'b0 || count2 !== 2'd0) begin
            n_err++;
            $display("FAIL ovf18_drain got v=%b count=%0d want 0/0", out_valid2, count2);
        end
    endtask

    // Test sequence
    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        reset_n = 1'b0;
        drive(1'b0, 17'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        in_valid2 = 1'b0; in_imm2 = 17'd0; in_mode2 = 2'b00; in_tag2 = 5'd0;
        out_ready2 = 1'b1; flush2 = 1'b0;
        @(posedge clock); #1;
        test_reset();
        test_sign_zero();
        test_branch_upper();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_ovf18();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
